switch_debouncer: RTL

- Multi-channel input conditioner for board push-buttons and slide switches (key1, SW0, SW1). Sits directly upstream of the WishboneSwitch instances and the interrupt controller's board-interrupt inputs.
- Synchronises raw asynchronous pad inputs, applies per-channel polarity inversion, and debounces with a per-channel stability counter.
- Outputs a clean level plus single-cycle rise/fall pulses, so the downstream blocks never see metastable or bouncing edges.

---
 rtl/switch_debouncer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions the board buttons and switches before they
// reach the bus switches and the interrupt controller. Each channel is
// optionally inverted, passed through a synchroniser chain, and debounced
// with a stability counter.
//
// Ports
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   i_raw    raw pad inputs, asynchronous to clk
//   o_level  debounced level, after the configured inversion
//   o_rise   one-cycle pulse when o_level goes 0->1
//   o_fall   one-cycle pulse when o_level goes 1->0
//   o_event  registered OR of all rise/fall bits, for one interrupt line
//
// SYNC_STAGES must be in 2..4. DEBOUNCE_CYCLES must be >= 1.

// One debounce channel. It consumes the already synchronised level.
module switch_debouncer_lane #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_SETTLING = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          differ;
  logic          accept;

  assign differ = (sync != level_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (differ) begin
          // With a one-cycle window the first differing sample is enough.
          if (CNT_LAST == '0) accept = 1'b1;
          else begin
            state_d = ST_SETTLING;
            cnt_d   = CW'(1);
          end
        end
      end
      default: begin
        if (!differ) begin
          // Input reverted before acceptance: a glitch, drop the count.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (accept) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
      level_d = sync;
      rise_d  = sync;
      fall_d  = ~sync;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
endmodule

module switch_debouncer #(
  parameter int                  CHANNELS        = 3,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 50000,
  parameter logic [CHANNELS-1:0] INVERT_MASK     = {CHANNELS{1'b0}},
  parameter logic [CHANNELS-1:0] RESET_LEVEL     = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] i_raw,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic                o_event
);
  // Stage 0 samples the pad; stage SYNC_STAGES-1 is the safe level.
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic event_q, event_d;

  always_comb begin
    sync_d[0] = i_raw ^ INVERT_MASK;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else          sync_q <= sync_d;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    switch_debouncer_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[c])
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .sync    (sync_q[SYNC_STAGES-1][c]),
      .o_level (o_level[c]),
      .o_rise  (o_rise[c]),
      .o_fall  (o_fall[c])
    );
  end

  // Registered so the interrupt line is one clean pulse a cycle after the
  // per-channel pulses, however many channels fired together.
  assign event_d = |(o_rise | o_fall);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) event_q <= 1'b0;
    else          event_q <= event_d;
  end

  assign o_event = event_q;
endmodule
